rtc_timekeeper: RTL and testbench
=================================

Name: rtc_timekeeper

Overview:
Parametrised real-time clock: prescales the system clock to 1 Hz and keeps 24-hour time (hh:mm:ss), with 12-hour/PM display outputs.
Two-state run/set controller. All user inputs are asynchronous button levels, synchronised and edge-detected internally; no logic is clocked by a button.
Sits between board button inputs and the 7-segment display driver.

Parameters:
CLK_DIV, 50000, clk cycles per second tick; must be ≥ 2; prescaler width = $clog2(CLK_DIV).
SYNC_STAGES, 2, flip-flop stages per button synchroniser; must be ≥ 2.
START_RUN, 0, 1 = leave reset in RUN; 0 = leave reset in SET.

Ports:
clk  input  1  system clock, all state on its rising edge
rst  input  1  asynchronous, active-low reset
mode  input  1  button; each rising edge toggles RUN/SET
set_min  input  1  button; each rising edge in SET increments minutes
set_hr  input  1  button; each rising edge in SET increments hours
am_pm  input  1  button; each rising edge in SET adds 12 h mod 24
sec  output  6  seconds 0..59
min  output  6  minutes 0..59
hr  output  5  hours 0..23
hr12  output  4  12-hour display value 1..12
pm  output  1  1 when hr ≥ 12
running  output  1  1 in RUN
tick  output  1  one-cycle pulse on the cycle sec/min/hr advance

Behaviour:
- Reset (rst low, asynchronous):
  - sec/min/hr = 0, prescaler = 0, synchronisers = 0.
  - State = RUN if START_RUN else SET.
  - tick = 0; hr12 = 12; pm = 0.
- Button path: SYNC_STAGES flops plus one history flop; pulse = last sync stage & ~history.
  - An input rising before edge k takes effect at edge k+SYNC_STAGES. Default: visible after the 3rd edge.
  - A held button gives exactly one pulse.
- States: SET, RUN. A mode pulse toggles the state; there is no other transition.
- RUN:
  - Prescaler counts 0..CLK_DIV-1.
  - At count CLK_DIV-1: prescaler → 0; sec+1; carry to min at 59→0; carry to hr at 59→0; hr wraps 23→0. tick=1 that cycle only (registered).
  - 23:59:59 → 00:00:00 in one tick.
  - set_min/set_hr/am_pm pulses are ignored.
- SET:
  - Prescaler held at 0; sec forced to 0; tick = 0.
  - set_min: min = (min+1) mod 60, no carry into hr.
  - set_hr: hr = (hr+1) mod 24.
  - am_pm: hr = hr<12 ? hr+12 : hr-12.
  - Simultaneous pulses, same edge: minutes update independently. set_hr and am_pm together give (hr+13) mod 24.
- Transitions:
  - SET→RUN: prescaler starts from 0; first tick CLK_DIV cycles after entering RUN.
  - RUN→SET: time frozen, sec cleared on that edge; a tick coinciding with the mode pulse is discarded.
- hr12/pm are combinational from hr: hr12 = (hr mod 12 == 0) ? 12 : hr mod 12.
- Reset mid-operation: immediate return to the reset values above; no pending pulses survive.
- All arithmetic uses explicit widths; no out-of-range value is ever stored.

Optional Feature:
Macro RTC_ALARM_EN.
- Defined:
  - Adds inputs alarm_sel (synchronised level) and alarm_on (synchronised level); adds output alarm (1 bit).
  - In SET with alarm_sel=1, set_min/set_hr/am_pm edit alarm_min/alarm_hr (reset 0:00, same rules) instead of the time.
  - alarm = running & alarm_on & (hr==alarm_hr) & (min==alarm_min), registered; it lasts the whole matching minute.
- Undefined: no alarm ports or registers; set inputs always edit the time.

Decomposition:
- Package rtc_pkg: state enum typedef (SET, RUN), constants SEC_MAX=59, MIN_MAX=59, HR_MAX=23, HR_HALF=12, and the field widths 6/6/5.
- One sub-module: btn_sync_edge (parameter SYNC_STAGES; ports clk, rst, in, pulse). Instantiated per button.

Test Plan:
- CLK_DIV=4, START_RUN=0: assert then release rst → hr:min:sec=00:00:00, running=0, hr12=12, pm=0, tick=0; sec still 0 after 40 cycles.
- CLK_DIV=4: in SET press set_hr 23×, set_min 59×, then mode → after 59×4 cycles reads 23:59:59; next tick → 00:00:00, tick high exactly 1 cycle.
- SET at 09:30: am_pm → 21:30, hr12=9, pm=1. Press am_pm and set_hr in the same cycle → 10:30. Hold set_min 20 cycles → min advances by 1 only.
- RUN: press set_min/set_hr/am_pm → time unchanged. Mode pulse at the tick cycle → state SET, sec=0, no tick.
- Mid-RUN at 12:34:56: pulse rst low for 1 cycle asynchronously → outputs 00:00:00 immediately; state back to SET.
- RTC_ALARM_EN, CLK_DIV=2: set alarm 00:01, alarm_on=1, run from 00:00:00 → alarm rises at 00:01:00, falls at 00:02:00; with alarm_on=0 it stays 0.

Source files
------------

// File: rtl/rtc_pkg.sv
// Shared types, limits and field-update helpers for the real-time clock.
package rtc_pkg;

    typedef enum logic {
        SET = 1'b0,
        RUN = 1'b1
    } rtc_state_t;

    localparam int SEC_W = 6;
    localparam int MIN_W = 6;
    localparam int HR_W  = 5;

    localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
    localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;
    localparam logic [HR_W-1:0]  HR_MAX  = 5'd23;
    localparam logic [HR_W-1:0]  HR_HALF = 5'd12;

    // Minutes + 1 with wrap at 60.
    function automatic logic [MIN_W-1:0] inc_min(input logic [MIN_W-1:0] v);
        return (v == MIN_MAX) ? '0 : v + MIN_W'(1);
    endfunction

    // Hours + 1 with wrap at 24.
    function automatic logic [HR_W-1:0] inc_hr(input logic [HR_W-1:0] v);
        return (v == HR_MAX) ? '0 : v + HR_W'(1);
    endfunction

    // Hour edit from the set buttons: optional +1 then optional +12, both mod 24,
    // so pressing both together yields (hr + 13) mod 24.
    function automatic logic [HR_W-1:0] edit_hr(input logic [HR_W-1:0] v,
                                                input logic do_inc,
                                                input logic do_flip);
        logic [HR_W-1:0] h1;
        h1 = do_inc ? inc_hr(v) : v;
        if (do_flip)
            return (h1 < HR_HALF) ? h1 + HR_HALF : h1 - HR_HALF;
        return h1;
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Button synchroniser with rising-edge detector: SYNC_STAGES flops, one history
// flop, and a single-cycle pulse per press regardless of hold time.
module btn_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   hist_reg;

    // Shift the raw level through the synchroniser and remember the last stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_reg <= '0;
            hist_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], in};
            hist_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign pulse = sync_reg[SYNC_STAGES-1] & ~hist_reg;

endmodule

// File: rtl/rtc_timekeeper.sv
// 24-hour real-time clock with run/set controller and 12-hour display outputs.
// CLK_DIV >= 2 clk cycles per second; SYNC_STAGES >= 2.
// Optional alarm comparator enabled by defining RTC_ALARM_EN.
module rtc_timekeeper
    import rtc_pkg::*;
#(
    parameter int CLK_DIV     = 50000,
    parameter int SYNC_STAGES = 2,
    parameter bit START_RUN   = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode,
    input  logic       set_min,
    input  logic       set_hr,
    input  logic       am_pm,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [4:0] hr,
    output logic [3:0] hr12,
    output logic       pm,
    output logic       running,
    output logic       tick
`ifdef RTC_ALARM_EN
    ,
    input  logic       alarm_sel,
    input  logic       alarm_on,
    output logic       alarm
`endif
);

    localparam int             PW       = $clog2(CLK_DIV);
    localparam logic [PW-1:0]  PRE_LAST = PW'(CLK_DIV - 1);
    localparam rtc_state_t     RST_ST   = START_RUN ? RUN : SET;

    // Button order: 0 mode, 1 set_min, 2 set_hr, 3 am_pm.
    logic [3:0] btn_raw;
    logic [3:0] btn_pulse;
    assign btn_raw = {am_pm, set_hr, set_min, mode};

    for (genvar gi = 0; gi < 4; gi++) begin : g_btn
        btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk  (clk),
            .rst  (rst),
            .in   (btn_raw[gi]),
            .pulse(btn_pulse[gi])
        );
    end

    logic mode_p, min_p, hr_p, ap_p;
    assign mode_p = btn_pulse[0];
    assign min_p  = btn_pulse[1];
    assign hr_p   = btn_pulse[2];
    assign ap_p   = btn_pulse[3];

    rtc_state_t state_reg, state_next;

    logic [PW-1:0]    pre_reg;
    logic [SEC_W-1:0] sec_reg;
    logic [MIN_W-1:0] min_reg;
    logic [HR_W-1:0]  hr_reg;
    logic             tick_reg;
    logic             edit_alarm;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= RST_ST;
        else      state_reg <= state_next;
    end

    // A mode pulse is the only way between SET and RUN.
    always_comb begin
        state_next = state_reg;
        if (mode_p) state_next = (state_reg == SET) ? RUN : SET;
    end

    // Controller outputs.
    always_comb begin
        running = (state_reg == RUN);
    end

    // Prescaler and time-of-day counters; a mode pulse in RUN wins over a tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_reg  <= '0;
            sec_reg  <= '0;
            min_reg  <= '0;
            hr_reg   <= '0;
            tick_reg <= 1'b0;
        end else begin
            tick_reg <= 1'b0;
            if (state_reg == RUN) begin
                if (mode_p) begin
                    pre_reg <= '0;
                    sec_reg <= '0;
                end else if (pre_reg == PRE_LAST) begin
                    pre_reg  <= '0;
                    tick_reg <= 1'b1;
                    if (sec_reg == SEC_MAX) begin
                        sec_reg <= '0;
                        if (min_reg == MIN_MAX) begin
                            min_reg <= '0;
                            hr_reg  <= inc_hr(hr_reg);
                        end else begin
                            min_reg <= min_reg + MIN_W'(1);
                        end
                    end else begin
                        sec_reg <= sec_reg + SEC_W'(1);
                    end
                end else begin
                    pre_reg <= pre_reg + PW'(1);
                end
            end else begin
                pre_reg <= '0;
                sec_reg <= '0;
                if (!edit_alarm) begin
                    if (min_p) min_reg <= inc_min(min_reg);
                    hr_reg <= edit_hr(hr_reg, hr_p, ap_p);
                end
            end
        end
    end

`ifdef RTC_ALARM_EN
    logic [SYNC_STAGES-1:0] sel_sync_reg;
    logic [SYNC_STAGES-1:0] on_sync_reg;
    logic [MIN_W-1:0]       alarm_min_reg;
    logic [HR_W-1:0]        alarm_hr_reg;
    logic                   alarm_reg;

    // Level synchronisers for the alarm select and enable switches.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_sync_reg <= '0;
            on_sync_reg  <= '0;
        end else begin
            sel_sync_reg <= {sel_sync_reg[SYNC_STAGES-2:0], alarm_sel};
            on_sync_reg  <= {on_sync_reg[SYNC_STAGES-2:0], alarm_on};
        end
    end

    assign edit_alarm = (state_reg == SET) & sel_sync_reg[SYNC_STAGES-1];

    // Alarm time edits and the registered minute-long match output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alarm_min_reg <= '0;
            alarm_hr_reg  <= '0;
            alarm_reg     <= 1'b0;
        end else begin
            if (edit_alarm) begin
                if (min_p) alarm_min_reg <= inc_min(alarm_min_reg);
                alarm_hr_reg <= edit_hr(alarm_hr_reg, hr_p, ap_p);
            end
            alarm_reg <= running & on_sync_reg[SYNC_STAGES-1] &
                         (hr_reg == alarm_hr_reg) & (min_reg == alarm_min_reg);
        end
    end

    assign alarm = alarm_reg;
`else
    assign edit_alarm = 1'b0;
`endif

    // 12-hour display view of the hour counter.
    always_comb begin
        logic [HR_W-1:0] h_mod;
        h_mod = (hr_reg >= HR_HALF) ? hr_reg - HR_HALF : hr_reg;
        pm    = (hr_reg >= HR_HALF);
        hr12  = (h_mod == '0) ? 4'd12 : h_mod[3:0];
    end

    assign sec  = sec_reg;
    assign min  = min_reg;
    assign hr   = hr_reg;
    assign tick = tick_reg;

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Self-checking bench for rtc_timekeeper: table of set-mode edits checked through a
// scoreboard queue, plus hand sequences for run/tick timing, rollover, mode-at-tick,
// asynchronous reset and (with RTC_ALARM_EN) the alarm window.
module tb_rtc_timekeeper;

`ifdef RTC_ALARM_EN
    localparam int DIV = 2;
`else
    localparam int DIV = 4;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       mode = 1'b0, set_min = 1'b0, set_hr = 1'b0, am_pm = 1'b0;
    logic [5:0] sec, min;
    logic [4:0] hr;
    logic [3:0] hr12;
    logic       pm, running, tick;
`ifdef RTC_ALARM_EN
    logic       alarm_sel = 1'b0, alarm_on = 1'b0, alarm;
`endif

    rtc_timekeeper #(.CLK_DIV(DIV), .SYNC_STAGES(2), .START_RUN(1'b0)) dut (
        .clk(clk), .rst(rst), .mode(mode), .set_min(set_min), .set_hr(set_hr),
        .am_pm(am_pm), .sec(sec), .min(min), .hr(hr), .hr12(hr12), .pm(pm),
        .running(running), .tick(tick)
`ifdef RTC_ALARM_EN
        , .alarm_sel(alarm_sel), .alarm_on(alarm_on), .alarm(alarm)
`endif
    );

    always #5 clk = ~clk;

    // Button encoding {mode, am_pm, set_hr, set_min}.
    localparam logic [3:0] B_MIN  = 4'b0001;
    localparam logic [3:0] B_HR   = 4'b0010;
    localparam logic [3:0] B_AP   = 4'b0100;
    localparam logic [3:0] B_MODE = 4'b1000;

    typedef struct {
        int hr;
        int min;
        int hr12;
        int pm;
    } exp_t;

    typedef struct {
        logic [3:0] btns;
        int         reps;
        exp_t       exp;
    } vec_t;

    vec_t vec[16];
    int   nv = 0;
    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic add_vec(input logic [3:0] b, input int reps, input int h,
                           input int m, input int h12, input int p);
        vec[nv].btns     = b;
        vec[nv].reps     = reps;
        vec[nv].exp.hr   = h;
        vec[nv].exp.min  = m;
        vec[nv].exp.hr12 = h12;
        vec[nv].exp.pm   = p;
        nv++;
    endtask

    // One-cycle press, release, then wait until the pulse has been applied.
    task automatic press(input logic [3:0] b);
        @(posedge clk); #1;
        {mode, am_pm, set_hr, set_min} = b;
        @(posedge clk); #1;
        {mode, am_pm, set_hr, set_min} = 4'b0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic press_n(input logic [3:0] b, input int n);
        for (int i = 0; i < n; i++) press(b);
    endtask

    initial begin
        int   tick_cnt;
        int   n;
        int   saved_min;
        int   saved_hr;
        exp_t got;

        // ---- reset state ----
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_sec", sec, 0);
        check("rst_min", min, 0);
        check("rst_hr", hr, 0);
        check("rst_running", running, 0);
        check("rst_hr12", hr12, 12);
        check("rst_pm", pm, 0);
        check("rst_tick", tick, 0);
        rst = 1'b1;
        tick_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (tick) tick_cnt++;
        end
        check("set_idle_sec", sec, 0);
        check("set_idle_ticks", tick_cnt, 0);

        // ---- table of SET-mode edits ----
        add_vec(B_HR,         1,  1,  0,  1, 0);
        add_vec(B_MIN,        1,  1,  1,  1, 0);
        add_vec(B_AP,         1, 13,  1,  1, 1);
        add_vec(B_AP | B_HR,  1,  2,  1,  2, 0);
        add_vec(B_MIN | B_HR, 1,  3,  2,  3, 0);
        add_vec(B_HR,         6,  9,  2,  9, 0);
        add_vec(B_MIN,       28,  9, 30,  9, 0);
        add_vec(B_AP,         1, 21, 30,  9, 1);
        add_vec(B_AP | B_HR,  1, 10, 30, 10, 0);
        add_vec(B_MIN,       30, 10,  0, 10, 0);
        add_vec(B_HR,        14,  0,  0, 12, 0);
        add_vec(B_AP,         1, 12,  0, 12, 1);
        add_vec(B_AP,         1,  0,  0, 12, 0);
        for (int i = 0; i < nv; i++) begin
            sb.push_back(vec[i].exp);
            press_n(vec[i].btns, vec[i].reps);
            got = sb.pop_front();
            check($sformatf("vec%0d_hr", i), hr, got.hr);
            check($sformatf("vec%0d_min", i), min, got.min);
            check($sformatf("vec%0d_hr12", i), hr12, got.hr12);
            check($sformatf("vec%0d_pm", i), pm, got.pm);
            check($sformatf("vec%0d_sec", i), sec, 0);
        end

        // ---- held set_min gives a single increment ----
        @(posedge clk); #1;
        set_min = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        set_min = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("hold_min", min, 1);
        check("hold_hr", hr, 0);

        // ---- run from 23:59:00 through midnight ----
        press_n(B_HR, 23);
        press_n(B_MIN, 58);
        check("pre_run_hr", hr, 23);
        check("pre_run_min", min, 59);
        press(B_MODE);
        check("run_running", running, 1);
        repeat (DIV - 2) @(negedge clk);
        check("first_tick_early_sec", sec, 0);
        check("first_tick_early_tick", tick, 0);
        @(negedge clk);
        check("first_tick_tick", tick, 1);
        check("first_tick_sec", sec, 1);
        @(negedge clk);
        check("first_tick_width", tick, 0);
        repeat (59 * DIV - DIV - 1) @(negedge clk);
        check("t235959_hr", hr, 23);
        check("t235959_min", min, 59);
        check("t235959_sec", sec, 59);
        repeat (DIV) @(negedge clk);
        check("midnight_hr", hr, 0);
        check("midnight_min", min, 0);
        check("midnight_sec", sec, 0);
        check("midnight_tick", tick, 1);
        @(negedge clk);
        check("midnight_tick_width", tick, 0);

        // ---- set buttons ignored in RUN ----
        press(B_MIN);
        press(B_HR);
        press(B_AP);
        check("run_ignore_hr", hr, 0);
        check("run_ignore_min", min, 0);
        check("run_ignore_running", running, 1);

        // ---- mode pulse landing on a tick cycle ----
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick && n < 100);
        check("tick_seen", tick, 1);
        saved_min = min;
        saved_hr  = hr;
        repeat (2 * DIV - 3) @(posedge clk);
        #1;
        mode = 1'b1;
        @(posedge clk); #1;
        mode = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mode_tick_before_running", running, 1);
        @(negedge clk);
        check("mode_tick_running", running, 0);
        check("mode_tick_sec", sec, 0);
        check("mode_tick_tick", tick, 0);
        check("mode_tick_min", min, saved_min);
        check("mode_tick_hr", hr, saved_hr);

        // ---- asynchronous reset at 12:34:56 ----
        press_n(B_HR, 12);
        press_n(B_MIN, 34);
        press(B_MODE);
        n = 0;
        while (sec != 6'd56 && n < 70 * DIV) begin
            @(negedge clk);
            n++;
        end
        check("t123456_hr", hr, 12);
        check("t123456_min", min, 34);
        check("t123456_sec", sec, 56);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_sec", sec, 0);
        check("async_rst_min", min, 0);
        check("async_rst_hr", hr, 0);
        check("async_rst_running", running, 0);
        check("async_rst_hr12", hr12, 12);
        @(negedge clk);
        rst = 1'b1;
        repeat (2 * DIV + 2) @(negedge clk);
        check("post_rst_running", running, 0);
        check("post_rst_sec", sec, 0);

`ifdef RTC_ALARM_EN
        // ---- alarm window 00:01 ----
        alarm_sel = 1'b1;
        repeat (3) @(posedge clk);
        press(B_MIN);
        alarm_sel = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("alarm_edit_time_min", min, 0);
        alarm_on = 1'b1;
        press(B_MODE);
        n = 0;
        while (!alarm && n < 200 * DIV) begin
            @(negedge clk);
            n++;
        end
        check("alarm_rise", alarm, 1);
        check("alarm_rise_min", min, 1);
        check("alarm_rise_sec", sec, 0);
        n = 0;
        while (alarm && n < 200 * DIV) begin
            @(negedge clk);
            n++;
        end
        check("alarm_fall", alarm, 0);
        check("alarm_fall_min", min, 2);
        check("alarm_fall_sec", sec, 0);

        // ---- alarm disabled never fires ----
        press(B_MODE);
        alarm_sel = 1'b1;
        repeat (3) @(posedge clk);
        press_n(B_MIN, 2);
        alarm_sel = 1'b0;
        alarm_on  = 1'b0;
        repeat (3) @(posedge clk);
        press(B_MODE);
        n = 0;
        for (int i = 0; i < 150 * DIV; i++) begin
            @(negedge clk);
            if (alarm) n++;
        end
        check("alarm_off_min_passed", (min >= 6'd4) ? 1 : 0, 1);
        check("alarm_off_count", n, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
